// File: rtl/arrow_board_seq.sv
// Arrow board lamp sequencer: steps a linear lamp bar through OFF, STEADY,
// FLASH, SWEEP, CHASE and ALTERNATE patterns at a programmable step rate.
// A new configuration is only taken when the running pattern wraps, when
// the board is idle, or on an explicit restart.
module arrow_board_seq #(
    parameter int N_LAMPS = 16,
    parameter int RATE_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mode,
    input  logic              dir,
    input  logic [RATE_W-1:0] rate,
    input  logic              restart,
    output logic [N_LAMPS-1:0] lamps,
    output logic              cycle_done
);

    localparam int SW = $clog2(N_LAMPS + 1);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_STEADY = 3'd1,
        MODE_FLASH = 3'd2,
        MODE_SWEEP = 3'd3,
        MODE_CHASE = 3'd4,
        MODE_ALT   = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } mode_t;

    mode_t             mode_q;
    logic              dir_q;
    logic [SW-1:0]     step_q;
    logic [RATE_W-1:0] cnt_q;
    logic              cycle_done_q;

    logic              tick;
    logic              running;
    logic [SW-1:0]     step_last;
    logic              wrap;
    logic              load;
    logic [N_LAMPS-1:0] pattern;

    // Tick, last-step index for the active pattern, and config-load decision.
    // Using >= lets a rate that drops below the current count end the step
    // at the very next edge instead of waiting for the counter to wrap.
    always_comb begin
        tick      = (cnt_q >= rate);
        running   = 1'b0;
        step_last = '0;
        case (mode_q)
            MODE_STEADY: begin running = 1'b1; step_last = '0;                  end
            MODE_FLASH:  begin running = 1'b1; step_last = SW'(1);              end
            MODE_SWEEP:  begin running = 1'b1; step_last = SW'(N_LAMPS);        end
            MODE_CHASE:  begin running = 1'b1; step_last = SW'(N_LAMPS - 1);    end
            MODE_ALT:    begin running = 1'b1; step_last = SW'(1);              end
            default:     begin running = 1'b0; step_last = '0;                  end
        endcase
        wrap = tick && (step_q == step_last);
        load = restart || !running || wrap;
    end

    // Config, step and prescale state; mode/dir are only sampled on a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= MODE_OFF;
            dir_q        <= 1'b0;
            step_q       <= '0;
            cnt_q        <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= wrap && running;
            if (load) begin
                mode_q <= mode_t'(mode);
                dir_q  <= dir;
                step_q <= '0;
                cnt_q  <= '0;
            end else if (tick) begin
                step_q <= step_q + SW'(1);
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + RATE_W'(1);
            end
        end
    end

    // Lamp decode from registered state, mirrored end-for-end when dir_q is set.
    always_comb begin
        pattern = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            case (mode_q)
                MODE_STEADY: pattern[i] = 1'b1;
                MODE_FLASH:  pattern[i] = (step_q == '0);
                MODE_SWEEP:  pattern[i] = (step_q != SW'(N_LAMPS)) && (SW'(i) <= step_q);
                MODE_CHASE:  pattern[i] = (SW'(i) == step_q);
                MODE_ALT:    pattern[i] = ((i % 2) == 0) ? (step_q == '0) : (step_q == SW'(1));
                default:     pattern[i] = 1'b0;
            endcase
        end
        lamps = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            lamps[i] = dir_q ? pattern[N_LAMPS-1-i] : pattern[i];
        end
    end

    assign cycle_done = cycle_done_q;

endmodule
